// File: rtl/window_2x2.sv
// Streaming 2x2 window generator: single-row line buffer plus a one-deep output register.
// Optional `WINDOW2X2_LAST_EN adds data_out_last, flagging the final window of each frame.
module window_2x2 #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DW    = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            data_in_valid,
    input  logic [DW-1:0]   data_in_data,
    output logic            data_in_ready,
    output logic            data_out_valid,
    output logic [4*DW-1:0] data_out_data,
    input  logic            data_out_ready
`ifdef WINDOW2X2_LAST_EN
    ,
    output logic            data_out_last
`endif
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // ready never looks at valid, and a held output stays stable until taken.
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [DW-1:0]   r_line [IMG_W];
    logic [DW-1:0]   r_left_cur;
    logic [DW-1:0]   r_left_top;
    logic            r_out_valid;
    logic [4*DW-1:0] r_out_data;

    logic            w_accept;
    logic            w_emit;
    logic            w_x_wrap;
    logic            w_y_wrap;
    logic [DW-1:0]   w_top;

    assign data_in_ready  = ~r_out_valid | data_out_ready;
    assign w_accept       = data_in_valid & data_in_ready;
    assign w_x_wrap       = (r_x == X_LAST);
    assign w_y_wrap       = (r_y == Y_LAST);
    assign w_top          = r_line[r_x];
    assign w_emit         = w_accept && (r_x != '0) && (r_y != '0);
    assign data_out_valid = r_out_valid;
    assign data_out_data  = r_out_data;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= w_y_wrap ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Row y=0 fills every entry before any is read into a window, so no reset here.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_line[r_x] <= data_in_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_left_cur <= '0;
            r_left_top <= '0;
        end else if (w_accept) begin
            r_left_cur <= data_in_data;
            r_left_top <= w_top;
        end
    end

    // A new window wins over draining; valid only falls on a pure drain.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {r_left_top, w_top, r_left_cur, data_in_data};
        end else if (data_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef WINDOW2X2_LAST_EN
    logic r_out_last;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_out_last <= 1'b0;
        end else if (w_emit) begin
            r_out_last <= w_x_wrap & w_y_wrap;
        end
    end

    assign data_out_last = r_out_last;
`endif

endmodule

// File: tb/tb_window_2x2.sv
// Self-checking bench for window_2x2: table of whole-frame runs plus hand-written
// backpressure, back-to-back frame and mid-frame reset sequences.
module tb_window_2x2;

    localparam int IMG_W = 16;
    localparam int IMG_H = 16;
    localparam int DW    = 16;
    localparam int WW    = 4 * DW;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          data_in_valid = 1'b0;
    logic [DW-1:0] data_in_data = '0;
    logic          data_in_ready;
    logic          data_out_valid;
    logic [WW-1:0] data_out_data;
    logic          data_out_ready = 1'b0;
`ifdef WINDOW2X2_LAST_EN
    logic          data_out_last;
`endif

    window_2x2 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .data_in_valid  (data_in_valid),
        .data_in_data   (data_in_data),
        .data_in_ready  (data_in_ready),
        .data_out_valid (data_out_valid),
        .data_out_data  (data_out_data),
        .data_out_ready (data_out_ready)
`ifdef WINDOW2X2_LAST_EN
        ,
        .data_out_last  (data_out_last)
`endif
    );

    always #5 CLK = ~CLK;

    logic [WW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [WW-1:0] got_q[$];
    int            chk_total = 0;
    int            chk_pass  = 0;

    typedef struct {
        int            off;
        int            vpct;
        int            rpct;
        int            exp_cnt;
        logic [WW-1:0] exp_first;
        logic [WW-1:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [WW-1:0] win(input int tl, input int tr, input int bl, input int br);
        logic [DW-1:0] a, b, c, d;
        a = tl[DW-1:0];
        b = tr[DW-1:0];
        c = bl[DW-1:0];
        d = br[DW-1:0];
        return {a, b, c, d};
    endfunction

    // Scoreboard: every output handshake pops one expected window.
    logic [WW-1:0] mon_exp;
    logic          mon_last;
    always @(negedge CLK) begin
        if (RESET && data_out_valid && data_out_ready) begin
            got_q.push_back(data_out_data);
            if (exp_q.size() == 0) begin
                check("unexpected_window", data_out_data, '0);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_last = exp_last_q.pop_front();
                check("window", data_out_data, mon_exp);
`ifdef WINDOW2X2_LAST_EN
                check("last_flag", data_out_last, mon_last);
`endif
            end
        end
    end

    // Offers pixels first_idx..last_idx of a frame (value off+idx) with random bubbles
    // and random downstream ready; entered and left at 1 time unit after a rising edge.
    task automatic drive_pixels(input int off, input int first_idx, input int last_idx,
                                input int vpct, input int rpct);
        for (int idx = first_idx; idx <= last_idx; idx++) begin
            int  x;
            int  y;
            int  guard;
            bit  accepted;
            x = idx % IMG_W;
            y = idx / IMG_W;
            guard = 0;
            accepted = 1'b0;
            while (!accepted) begin
                data_out_ready = ($urandom_range(99) < rpct);
                data_in_valid  = ($urandom_range(99) < vpct);
                data_in_data   = DW'(off + idx);
                #1;
                if (data_in_valid && data_in_ready) begin
                    accepted = 1'b1;
                    if (x >= 1 && y >= 1) begin
                        exp_q.push_back(win(off + idx - IMG_W - 1, off + idx - IMG_W,
                                            off + idx - 1, off + idx));
                        exp_last_q.push_back((x == IMG_W - 1) && (y == IMG_H - 1));
                    end
                end
                @(posedge CLK);
                #1;
                guard++;
                if (!accepted && guard > 1000) begin
                    check("input_timeout", idx, -1);
                    data_in_valid = 1'b0;
                    return;
                end
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic drain();
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !data_out_valid) break;
            @(posedge CLK);
            #1;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_idle", data_out_valid, 1'b0);
    endtask

    initial begin
        vecs[0] = '{0,    100, 100, 225, win(0, 1, 16, 17), win(238, 239, 254, 255)};
        vecs[1] = '{0,    50,  60,  225, win(0, 1, 16, 17), win(238, 239, 254, 255)};
        vecs[2] = '{500,  70,  40,  225, win(500, 501, 516, 517), win(738, 739, 754, 755)};
        vecs[3] = '{2000, 90,  85,  225, win(2000, 2001, 2016, 2017), win(2238, 2239, 2254, 2255)};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("reset_out_valid", data_out_valid, 1'b0);
        check("reset_out_data", data_out_data, '0);
`ifdef WINDOW2X2_LAST_EN
        check("reset_out_last", data_out_last, 1'b0);
`endif
        #2 RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("idle_in_ready", data_in_ready, 1'b1);
        check("idle_out_valid", data_out_valid, 1'b0);

        // Whole frames under different valid/ready densities
        for (int v = 0; v < 4; v++) begin
            got_q.delete();
            drive_pixels(vecs[v].off, 0, IMG_W * IMG_H - 1, vecs[v].vpct, vecs[v].rpct);
            drain();
            check("frame_count", got_q.size(), vecs[v].exp_cnt);
            check("frame_first", got_q[0], vecs[v].exp_first);
            check("frame_last", got_q[got_q.size() - 1], vecs[v].exp_last);
        end

        // Back-to-back frames with no gap
        got_q.delete();
        drive_pixels(0, 0, IMG_W * IMG_H - 1, 100, 100);
        drive_pixels(1000, 0, IMG_W * IMG_H - 1, 100, 100);
        drain();
        check("b2b_count", got_q.size(), 450);
        check("b2b_f1_last", got_q[224], win(238, 239, 254, 255));
        check("b2b_f2_first", got_q[225], win(1000, 1001, 1016, 1017));

        // Latency and backpressure on the first window
        got_q.delete();
        drive_pixels(0, 0, 16, 100, 100);
        check("row_start_no_window", data_out_valid, 1'b0);
        drive_pixels(0, 17, 17, 100, 100);
        data_out_ready = 1'b0;
        check("first_latency_valid", data_out_valid, 1'b1);
        check("first_latency_data", data_out_data, win(0, 1, 16, 17));
        data_in_valid = 1'b1;
        data_in_data  = DW'(18);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", data_in_ready, 1'b0);
            check("stall_out_valid", data_out_valid, 1'b1);
            check("stall_out_data", data_out_data, win(0, 1, 16, 17));
            @(posedge CLK);
            #1;
        end
        drive_pixels(0, 18, IMG_W * IMG_H - 1, 100, 100);
        drain();
        check("bp_count", got_q.size(), 225);
        check("bp_second", got_q[1], win(1, 2, 17, 18));

        // Asynchronous reset right after pixel (5,7)
        drive_pixels(0, 0, 7 * IMG_W + 5, 100, 100);
        check("pre_reset_valid", data_out_valid, 1'b1);
        #2 RESET = 1'b0;
        #1;
        check("async_reset_valid", data_out_valid, 1'b0);
        check("async_reset_data", data_out_data, '0);
        check("async_reset_in_ready", data_in_ready, 1'b1);
`ifdef WINDOW2X2_LAST_EN
        check("async_reset_last", data_out_last, 1'b0);
`endif
        exp_q.delete();
        exp_last_q.delete();
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b1;
        @(posedge CLK);
        #1;
        got_q.delete();
        drive_pixels(0, 0, IMG_W * IMG_H - 1, 50, 50);
        drain();
        check("post_reset_count", got_q.size(), 225);
        check("post_reset_first", got_q[0], win(0, 1, 16, 17));
        check("post_reset_last", got_q[224], win(238, 239, 254, 255));

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

// File: doc/window_2x2.md
# window_2x2

Streaming 2x2 window generator sitting directly downstream of the downsample stage. It consumes the decimated pixel stream in raster order and emits every stride-1 2x2 neighbourhood as one packed 64-bit word, using the same valid/ready handshake on both sides. It holds a single-row line buffer plus a one-deep registered output stage, and feeds the filter/reduction stages that follow.

## Interface
- `IMG_W`, default 16: pixels per row of the incoming (already downsampled) image; range 2..256.
- `IMG_H`, default 16: rows per frame; range 2..256.
- `DW`, default 16: bits per pixel.
- `CLK` input 1: single clock; all state updates on its rising edge.
- `RESET` input 1: asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to `CLK`.
- `data_in_valid` input 1: upstream pixel valid.
- `data_in_data` input DW: upstream pixel.
- `data_in_ready` output 1: block accepts a pixel this cycle.
- `data_out_valid` output 1: window word valid.
- `data_out_data` output 4*DW: packed window. [DW-1:0] = bottom-right (x,y); [2DW-1:DW] = bottom-left (x-1,y); [3DW-1:2DW] = top-right (x,y-1); [4DW-1:3DW] = top-left (x-1,y-1).
- `data_out_ready` input 1: downstream accepts the window.
- `data_out_last` output 1: present only with `WINDOW2X2_LAST_EN`; see Configuration.

## Operation
- Pixel position counters: `x` in 0..IMG_W-1 and `y` in 0..IMG_H-1, each sized `$clog2` of its limit. Both advance only on an accepted input, i.e. `data_in_valid & data_in_ready`.
- Counter advance: `x` increments. When `x==IMG_W-1` it wraps to 0 and `y` increments. When `y==IMG_H-1` at the same time, `y` wraps to 0, which starts the next frame.
- Line buffer: IMG_W entries of DW bits.
  - On each accepted pixel, entry[x] is read (giving pixel (x,y-1)) and then overwritten with the current pixel; this is read-before-write within the same cycle.
  - Registers `left_cur` and `left_top` hold the current pixel and the read-out value from the previous accepted pixel.
- Window emission: an accepted pixel with `x>=1 && y>=1` loads the output register with {left_top, top_read, left_cur, current} and sets `out_valid`.
- Pixels with `x==0` or `y==0` are consumed and update the buffers, but emit nothing.
- Windows never straddle rows or frames. Each frame yields exactly (IMG_W-1)*(IMG_H-1) windows, in raster order.
- Output stage handshake:
  - `data_in_ready = ~out_valid | data_out_ready`.
  - `out_valid` clears when the output handshake completes and no new window loads in that cycle.
  - Simultaneous output handshake and new window load: the register takes the new window and `out_valid` stays 1.
- Line buffer contents are not reset. Row y=0 overwrites every entry before any of them is read for a window.

## Timing
- Reset values: `data_out_valid`=0, `data_out_data`=0, `data_out_last`=0, `x`=0, `y`=0.
- `data_in_ready`=1 while out of reset with an empty output register.
- Latency: a window appears on `data_out_*` in the cycle after its bottom-right pixel is accepted. Full throughput is 1 pixel/cycle when `data_out_ready` is held high.
- Backpressure: while `data_out_valid & ~data_out_ready`, `data_in_ready`=0 and `data_out_data` holds stable. Input stalls propagate combinationally through `data_in_ready` only.
- `data_in_ready` does not depend on `data_in_valid`, and there is no combinational path from `data_in_valid` to `data_out_valid`.
- Input bubbles (`data_in_valid`=0) advance nothing; they only allow a pending output to drain.
- Reset mid-frame:
  - Any pending window is discarded immediately.
  - The first accepted pixel after reset is treated as (0,0) of a new frame.

## Configuration
- `WINDOW2X2_LAST_EN` defined:
  - Adds the `data_out_last` port and a registered flag.
  - The flag is 1 exactly when the held window's bottom-right pixel is (IMG_W-1, IMG_H-1), i.e. the last window of the frame.
  - It is loaded and held alongside `data_out_data`.
- Macro undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- 16x16 frame with pixel = y*16+x, `data_out_ready`=1, continuous valid:
  - Exactly 225 windows are produced.
  - First window is {tl=0, tr=1, bl=16, br=17}, one cycle after pixel 17 is accepted.
  - Last window is {238,239,254,255}.
- Backpressure: drop `data_out_ready` for 5 cycles while the window {0,1,16,17} is held:
  - `data_in_ready`=0 and the output stays stable for all 5 cycles.
  - No pixel is lost; the next window is {1,2,17,18}.
- Random input bubbles (50% valid) together with random `data_out_ready`: the output sequence matches the reference 225-window list in order.
- Two back-to-back frames, the second frame's pixels offset by +1000:
  - Second frame's first window is {1000,1001,1016,1017}.
  - No window mixes pixels from the two frames.
- Assert `RESET` low mid-frame after pixel (5,7), asynchronously between clock edges:
  - `data_out_valid` drops immediately.
  - A subsequent fresh frame reproduces the 225-window list.
- With `WINDOW2X2_LAST_EN`: `data_out_last`=1 only on window {238,239,254,255}, once per frame, and 0 after reset.
